// File: rtl/alu_muldiv.sv
// Iterative multiply/divide unit with HI/LO result registers.
// One bit per cycle: shift-add multiply, restoring shift-subtract divide.
module alu_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FINISH
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               div_q, div_d;
    logic               neg_q, neg_d;
    logic               rneg_q, rneg_d;
    logic               done_q, done_d;

    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     m_sum;
    logic [WIDTH:0]     d_sh, d_diff;
    logic               d_ge;
    logic [2*WIDTH-1:0] mul_next, div_next, prod;
    logic [WIDTH-1:0]   quo, rem;

    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

    // Operand magnitudes and one iteration step of each algorithm.
    always_comb begin
        a_neg    = ~op[0] & src_a[WIDTH-1];
        b_neg    = ~op[0] & src_b[WIDTH-1];
        mag_a    = a_neg ? -src_a : src_a;
        mag_b    = b_neg ? -src_b : src_b;
        m_sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                 + (acc_q[0] ? {1'b0, b_q} : '0);
        mul_next = {m_sum, acc_q[WIDTH-1:1]};
        d_sh     = acc_q[2*WIDTH-1:WIDTH-1];
        d_ge     = (d_sh >= {1'b0, b_q});
        d_diff   = d_sh - {1'b0, b_q};
        div_next = d_ge ? {d_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1}
                        : {d_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        prod     = neg_q ? -acc_q : acc_q;
        quo      = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem      = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    end

    // Next-state, datapath and result-register update.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        b_d     = b_q;
        div_d   = div_q;
        neg_d   = neg_q;
        rneg_d  = rneg_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start && !op[2]) begin
                    state_d = CALC;
                    cnt_d   = '0;
                    acc_d   = {{WIDTH{1'b0}}, mag_a};
                    b_d     = mag_b;
                    div_d   = op[1];
                    // Divide by zero keeps quotient all ones, remainder = dividend.
                    neg_d   = (a_neg ^ b_neg) & ~(op[1] & ~|src_b);
                    rneg_d  = op[1] & a_neg;
                end else if (start && op == 3'b100) begin
                    hi_d   = src_a;
                    done_d = 1'b1;
                end else if (start && op == 3'b101) begin
                    lo_d   = src_a;
                    done_d = 1'b1;
                end
            end
            CALC: begin
                acc_d = div_q ? div_next : mul_next;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = FINISH;
                end
            end
            FINISH: begin
                state_d = IDLE;
                done_d  = 1'b1;
                if (div_q) begin
                    hi_d = rem;
                    lo_d = quo;
                end else begin
                    hi_d = prod[2*WIDTH-1:WIDTH];
                    lo_d = prod[WIDTH-1:0];
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers, cleared asynchronously by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            b_q     <= '0;
            div_q   <= 1'b0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            b_q     <= b_d;
            div_q   <= div_d;
            neg_q   <= neg_d;
            rneg_q  <= rneg_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_alu_muldiv.sv
// Self-checking bench for alu_muldiv: directed vector table,
// hand-written corner sequences and randomized model comparison.
module tb_alu_muldiv;

    localparam int W = 32;

    logic         clk;
    logic         reset;
    logic         start;
    logic [2:0]   op;
    logic [W-1:0] src_a;
    logic [W-1:0] src_b;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int n_chk  = 0;
    int n_fail = 0;

    alu_muldiv #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .src_a (src_a),
        .src_b (src_b),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        bit          poke;
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
        int          busy_n;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Reference: results straight from signed/unsigned 64-bit arithmetic.
    task automatic ref_model(input logic [2:0] o, input logic [31:0] a,
                             input logic [31:0] b, output logic [31:0] h,
                             output logic [31:0] l);
        longint          sa, sb, q, r;
        longint unsigned ua, ub, p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        h = '0;
        l = '0;
        case (o)
            3'd0: begin
                p = longint'(sa * sb);
                h = p[63:32];
                l = p[31:0];
            end
            3'd1: begin
                p = ua * ub;
                h = p[63:32];
                l = p[31:0];
            end
            3'd2: begin
                if (b == 0) begin
                    h = a;
                    l = '1;
                end else begin
                    q = sa / sb;
                    r = sa % sb;
                    h = r[31:0];
                    l = q[31:0];
                end
            end
            default: begin
                if (b == 0) begin
                    h = a;
                    l = '1;
                end else begin
                    h = a % b;
                    l = a / b;
                end
            end
        endcase
    endtask

    // Called at a negedge; returns at the negedge where done is seen.
    task automatic do_op(input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] b, input bit poke,
                         output int edges, output int busy_n,
                         output bit changed);
        logic [31:0] h0, l0;
        h0 = hi;
        l0 = lo;
        changed = 0;
        busy_n = 0;
        op = o;
        src_a = a;
        src_b = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        op = 3'($urandom_range(0, 3));
        src_a = $urandom;
        src_b = $urandom;
        edges = 0;
        while (!done && edges < 200) begin
            if (busy) busy_n++;
            if (hi !== h0 || lo !== l0) changed = 1;
            if (poke && edges == 5) begin
                start = 1'b1;
                op = 3'd0;
                src_a = 32'd3;
                src_b = 32'd3;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            edges++;
        end
        start = 1'b0;
    endtask

    initial begin
        int edges, busy_n;
        bit changed;
        logic [31:0] eh, el, h0, l0;
        logic [2:0] ro;
        logic [31:0] ra, rb;

        vecs.push_back('{3'd0, 32'hFFFFFFFF, 32'h00000005, 0,
                         32'hFFFFFFFF, 32'hFFFFFFFB, 33, 33});
        vecs.push_back('{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 0,
                         32'hFFFFFFFE, 32'h00000001, 33, 33});
        vecs.push_back('{3'd2, 32'hFFFFFFF9, 32'h00000002, 0,
                         32'hFFFFFFFF, 32'hFFFFFFFD, 33, 33});
        vecs.push_back('{3'd2, 32'h80000000, 32'hFFFFFFFF, 0,
                         32'h00000000, 32'h80000000, 33, 33});
        vecs.push_back('{3'd2, 32'h00000007, 32'hFFFFFFFE, 0,
                         32'h00000001, 32'hFFFFFFFD, 33, 33});
        vecs.push_back('{3'd2, 32'hFFFFFFF0, 32'h00000000, 0,
                         32'hFFFFFFF0, 32'hFFFFFFFF, 33, 33});
        vecs.push_back('{3'd0, 32'h80000000, 32'h80000000, 0,
                         32'h40000000, 32'h00000000, 33, 33});
        vecs.push_back('{3'd3, 32'hFFFFFFFF, 32'h00000001, 0,
                         32'h00000000, 32'hFFFFFFFF, 33, 33});
        vecs.push_back('{3'd3, 32'h00001234, 32'h00000000, 1,
                         32'h00001234, 32'hFFFFFFFF, 33, 33});
        vecs.push_back('{3'd4, 32'hA5A5A5A5, 32'h00000000, 0,
                         32'hA5A5A5A5, 32'hFFFFFFFF, 0, 0});
        vecs.push_back('{3'd5, 32'h5A5A5A5A, 32'h00000000, 0,
                         32'hA5A5A5A5, 32'h5A5A5A5A, 0, 0});

        reset = 1'b1;
        start = 1'b0;
        op = '0;
        src_a = '0;
        src_b = '0;
        #1;
        check("reset_state", 64'({busy, done, hi, lo}), 64'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("idle_after_reset", 64'({busy, done, hi, lo}), 64'd0);

        foreach (vecs[i]) begin
            do_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].poke,
                  edges, busy_n, changed);
            check($sformatf("v%0d_latency", i), 64'(edges), 64'(vecs[i].lat));
            check($sformatf("v%0d_busy_cycles", i), 64'(busy_n),
                  64'(vecs[i].busy_n));
            check($sformatf("v%0d_hi", i), 64'(hi), 64'(vecs[i].hi));
            check($sformatf("v%0d_lo", i), 64'(lo), 64'(vecs[i].lo));
            check($sformatf("v%0d_hold", i), 64'(changed), 64'd0);
            check($sformatf("v%0d_busy_at_done", i), 64'(busy), 64'd0);
            @(negedge clk);
            check($sformatf("v%0d_done_pulse", i), 64'(done), 64'd0);
        end

        do_op(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, edges, busy_n, changed);
        check("b2b_mult_hi", 64'(hi), 64'hFFFFFFFE);
        check("b2b_mult_lo", 64'(lo), 64'h00000001);
        do_op(3'd3, 32'd7, 32'd2, 0, edges, busy_n, changed);
        check("b2b_divu_latency", 64'(edges), 64'd33);
        check("b2b_divu_lo", 64'(lo), 64'h3);
        check("b2b_divu_hi", 64'(hi), 64'h1);
        @(negedge clk);

        h0 = hi;
        l0 = lo;
        for (int k = 6; k < 8; k++) begin
            op = 3'(k);
            src_a = 32'h12345678;
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            check($sformatf("rsv%0d_done", k), 64'(done), 64'd0);
            check($sformatf("rsv%0d_busy", k), 64'(busy), 64'd0);
            @(negedge clk);
            check($sformatf("rsv%0d_hilo", k), 64'({hi, lo}), {h0, l0});
        end

        op = 3'd0;
        src_a = 32'hFFFFFFFF;
        src_b = 32'd5;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 10; k++) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("abort_outputs", 64'({busy, done, hi, lo}), 64'd0);
        #1 reset = 1'b0;
        @(negedge clk);
        do_op(3'd0, 32'd3, 32'd4, 0, edges, busy_n, changed);
        check("post_reset_latency", 64'(edges), 64'd33);
        check("post_reset_hilo", 64'({hi, lo}), 64'h0000_0000_0000_000C);

        for (int i = 0; i < 60; i++) begin
            ro = 3'($urandom_range(0, 3));
            ra = $urandom;
            if ($urandom_range(0, 7) == 0) ra = 32'h80000000;
            case ($urandom_range(0, 7))
                0:       rb = 32'd0;
                1:       rb = 32'd1;
                2:       rb = 32'hFFFFFFFF;
                3:       rb = 32'($urandom_range(1, 15));
                default: rb = $urandom;
            endcase
            ref_model(ro, ra, rb, eh, el);
            do_op(ro, ra, rb, 0, edges, busy_n, changed);
            check($sformatf("rnd%0d_op%0d_%h_%h", i, ro, ra, rb),
                  64'({hi, lo}), {eh, el});
            check($sformatf("rnd%0d_latency", i), 64'(edges), 64'd33);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_muldiv.md
ALU_MULDIV -- requirements
Module: alu_muldiv

Interface
REQ-001 Parameter WIDTH, default 32, operand and HI/LO register width; SHALL be even and >= 4.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request; sampled only on a rising edge while busy=0.
REQ-005 op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 110/111 reserved.
REQ-006 src_a  input  WIDTH  multiplicand, dividend or MTHI/MTLO data.
REQ-007 src_b  input  WIDTH  multiplier or divisor.
REQ-008 busy  output  1  high while an iterative operation is in progress.
REQ-009 done  output  1  one-cycle pulse in the cycle HI/LO first show a new result.
REQ-010 hi  output  WIDTH  HI register: product upper half or remainder.
REQ-011 lo  output  WIDTH  LO register: product lower half or quotient.

Function
REQ-012 The state machine SHALL have states IDLE, CALC and FINISH. busy SHALL be 1 in CALC and FINISH and 0 in IDLE.
REQ-013 IDLE->CALC SHALL occur on an edge with start=1 and op in 000..011. On that edge the block SHALL latch op, the operand magnitudes and the result sign, and clear the iteration counter.
REQ-014 CALC SHALL last exactly WIDTH cycles, processing one bit per cycle: shift-add for multiply, restoring shift-subtract for divide. It SHALL then go to FINISH.
REQ-015 FINISH SHALL last one cycle: apply the sign correction, write hi/lo on the exiting edge, and return to IDLE. done SHALL be 1 for the following cycle only.
REQ-016 Latency: start sampled at edge E0 -> hi/lo updated and done=1 after edge E0+WIDTH+1; busy=0 after that same edge.
REQ-017 A new start SHALL be accepted in the cycle done=1 (back-to-back operation).
REQ-018 start while busy=1 SHALL be ignored; operands and op SHALL NOT be re-sampled.
REQ-019 MULT/MULTU: {hi,lo} SHALL equal the full 2*WIDTH-bit product, signed or unsigned respectively.
REQ-020 DIV: lo = quotient truncated toward zero; hi = remainder with the dividend's sign.
REQ-021 DIVU: unsigned quotient in lo and unsigned remainder in hi.
REQ-022 DIV of most-negative by -1: lo = most-negative (two's-complement wrap), hi = 0; no error signalled.
REQ-023 Divide by zero (DIV or DIVU): lo = all ones, hi = src_a as latched; normal latency and done pulse.
REQ-024 MTHI/MTLO in IDLE: hi or lo respectively SHALL take src_a on that edge; done=1 next cycle; busy SHALL stay 0; the other register is unchanged.
REQ-025 Reserved op with start=1 SHALL be a no-op: no state change, no done pulse.
REQ-026 hi/lo SHALL hold their values in all cycles except the FINISH exit edge and MTHI/MTLO edges. Intermediate values SHALL NOT be visible on hi/lo.

Reset
REQ-027 reset=1 SHALL immediately, without a clock, force: state IDLE, busy=0, done=0, hi=0, lo=0, counter and datapath registers 0.
REQ-028 Reset asserted mid-CALC or mid-FINISH SHALL abort the operation with no partial result written. A start on the first edge after release SHALL be accepted normally.

Verification (WIDTH=32)
REQ-029 MULT src_a=FFFFFFFF, src_b=00000005 -> after 33 edges, hi=FFFFFFFF, lo=FFFFFFFB; done high exactly one cycle; busy high 33 cycles.
REQ-030 MULTU FFFFFFFF x FFFFFFFF -> hi=FFFFFFFE, lo=00000001. Then immediate start of DIVU 7/2 in the done cycle -> lo=00000003, hi=00000001.
REQ-031 DIV FFFFFFF9 / 00000002 -> lo=FFFFFFFD, hi=FFFFFFFF. DIV 80000000 / FFFFFFFF -> lo=80000000, hi=00000000.
REQ-032 DIVU 00001234 / 0 -> lo=FFFFFFFF, hi=00001234. start pulsed with new operands during busy -> result unaffected.
REQ-033 MTHI A5A5A5A5 then MTLO 5A5A5A5A -> hi=A5A5A5A5, lo=5A5A5A5A; each gives a done pulse one cycle later; busy never asserts.
REQ-034 reset pulsed between edges 10 and 11 of a MULT -> busy, done, hi and lo are 0 before the next edge. A new MULT 3x4 after release -> hi=0, lo=0000000C.
